// File: rtl/acc_status_unit_pkg.sv
// Shared definitions for the accumulator/status stage: widths, opcodes,
// condition codes, flag layout and FSM states.
package acc_status_unit_pkg;

  localparam int unsigned W      = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned F_C = 3;
  localparam int unsigned F_V = 2;
  localparam int unsigned F_N = 1;
  localparam int unsigned F_Z = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_CMP = 3'd4,
    OP_CLF = 3'd5,
    OP_TST = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [CC_W-1:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Field order places C in bit 3 and Z in bit 0.
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/acc_status_unit_if.sv
// Request/response bundle between the sequencer and the accumulator stage.
interface acc_status_unit_if;
  import acc_status_unit_pkg::*;

  logic              START;
  logic [OP_W-1:0]   OP;
  logic [W-1:0]      D;
  logic [CC_W-1:0]   CC;
  logic              BUSY;
  logic              DONE;
  logic [W-1:0]      ACC;
  logic [FLAG_W-1:0] FLAGS;
  logic              TAKEN;

  modport master (
    output START, OP, D, CC,
    input  BUSY, DONE, ACC, FLAGS, TAKEN
  );

  modport slave (
    input  START, OP, D, CC,
    output BUSY, DONE, ACC, FLAGS, TAKEN
  );

endinterface

// File: rtl/acc_status_unit_addsub.sv
// 8-bit adder/subtractor (M=1 subtracts) producing C, V, N and Z.
module acc_status_unit_addsub
  import acc_status_unit_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v,
  output logic         n,
  output logic         z
);

  logic [W-1:0] bx;
  logic [W-1:0] lo;
  logic         c6;
  logic [1:0]   hi;

  // Split at bit 7 so the carry into the MSB is available for overflow.
  assign bx = b ^ {W{m}};
  assign lo = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + W'(m);
  assign c6 = lo[W-1];
  assign hi = 2'(a[W-1]) + 2'(bx[W-1]) + 2'(c6);

  assign s = {hi[0], lo[W-2:0]};
  assign c = hi[1];
  assign v = hi[1] ^ c6;
  assign n = s[W-1];
  assign z = (s == '0);

endmodule

// File: rtl/acc_status_unit.sv
// Accumulator and status-register stage: one operation per START handshake,
// writeback one cycle after acceptance, DONE pulse the cycle after that.
module acc_status_unit
  import acc_status_unit_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  acc_status_unit_if.slave bus
);

  state_e       state;
  op_e          op_r;
  logic [W-1:0] d_r;
  cc_e          cc_r;
  logic [W-1:0] acc_r;
  flags_t       flags_r;
  logic         taken_r;
  logic         busy_r;
  logic         done_r;

  logic         sub_mode;
  logic [W-1:0] sum;
  logic         as_c;
  logic         as_v;
  logic         as_n;
  logic         as_z;

  assign sub_mode = (op_r == OP_SUB) || (op_r == OP_CMP);

  acc_status_unit_addsub u_addsub (
    .a (acc_r),
    .b (d_r),
    .m (sub_mode),
    .s (sum),
    .c (as_c),
    .v (as_v),
    .n (as_n),
    .z (as_z)
  );

  // Branch condition against the currently held flags.
  function automatic logic cond_eval(input cc_e cc, input flags_t f);
    logic r;
    r = 1'b0;
    case (cc)
      CC_EQ: r = f.z;
      CC_NE: r = !f.z;
      CC_CS: r = f.c;
      CC_CC: r = !f.c;
      CC_MI: r = f.n;
      CC_PL: r = !f.n;
      CC_VS: r = f.v;
      CC_VC: r = !f.v;
      CC_HI: r = f.c & !f.z;
      CC_LS: r = !f.c | f.z;
      CC_GE: r = (f.n == f.v);
      CC_LT: r = (f.n != f.v);
      CC_GT: r = !f.z & (f.n == f.v);
      CC_LE: r = f.z | (f.n != f.v);
      CC_AL: r = 1'b1;
      CC_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      op_r    <= OP_NOP;
      d_r     <= '0;
      cc_r    <= CC_EQ;
      acc_r   <= '0;
      flags_r <= '0;
      taken_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            op_r   <= op_e'(bus.OP);
            d_r    <= bus.D;
            cc_r   <= cc_e'(bus.CC);
            busy_r <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_r)
            OP_LDA: begin
              acc_r     <= d_r;
              flags_r.n <= d_r[W-1];
              flags_r.z <= (d_r == '0);
            end
            OP_ADD, OP_SUB: begin
              acc_r   <= sum;
              flags_r <= '{c: as_c, v: as_v, n: as_n, z: as_z};
            end
            OP_CMP:  flags_r <= '{c: as_c, v: as_v, n: as_n, z: as_z};
            OP_CLF:  flags_r <= '0;
            OP_TST:  taken_r <= cond_eval(cc_r, flags_r);
            default: ;
          endcase
          done_r <= 1'b1;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
  assign bus.ACC   = acc_r;
  assign bus.FLAGS = flags_r;
  assign bus.TAKEN = taken_r;

endmodule

// File: tb/tb_acc_status_unit.sv
// Scoreboard bench for acc_status_unit: directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_acc_status_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  acc_status_unit_if bus ();

  acc_status_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int acc;
    int flags;
    int taken;
    int cyc;
    int op;
  } exp_t;

  exp_t sb[$];

  // Reference architectural state.
  int m_acc;
  int m_c, m_v, m_n, m_z;
  int m_taken;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int m_flags();
    return m_c * 8 + m_v * 4 + m_n * 2 + m_z;
  endfunction

  function automatic int m_cond(input int cc);
    case (cc)
      0:  return m_z;
      1:  return 1 - m_z;
      2:  return m_c;
      3:  return 1 - m_c;
      4:  return m_n;
      5:  return 1 - m_n;
      6:  return m_v;
      7:  return 1 - m_v;
      8:  return (m_c == 1 && m_z == 0) ? 1 : 0;
      9:  return (m_c == 0 || m_z == 1) ? 1 : 0;
      10: return (m_n == m_v) ? 1 : 0;
      11: return (m_n != m_v) ? 1 : 0;
      12: return (m_z == 0 && m_n == m_v) ? 1 : 0;
      13: return (m_z == 1 || m_n != m_v) ? 1 : 0;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_c = 0; m_v = 0; m_n = 0; m_z = 0; m_taken = 0;
  endtask

  task automatic model_apply(input int op, input int d, input int cc);
    int r, sr;
    case (op)
      1: begin
        m_acc = d;
        m_n = (d >= 128) ? 1 : 0;
        m_z = (d == 0) ? 1 : 0;
      end
      2: begin
        r  = m_acc + d;
        sr = to_signed8(m_acc) + to_signed8(d);
        m_c = (r > 255) ? 1 : 0;
        m_v = (sr > 127 || sr < -128) ? 1 : 0;
        m_acc = r % 256;
        m_n = (m_acc >= 128) ? 1 : 0;
        m_z = (m_acc == 0) ? 1 : 0;
      end
      3, 4: begin
        r  = (m_acc - d + 256) % 256;
        sr = to_signed8(m_acc) - to_signed8(d);
        m_c = (m_acc >= d) ? 1 : 0;
        m_v = (sr > 127 || sr < -128) ? 1 : 0;
        m_n = (r >= 128) ? 1 : 0;
        m_z = (r == 0) ? 1 : 0;
        if (op == 3) m_acc = r;
      end
      5: begin
        m_c = 0; m_v = 0; m_n = 0; m_z = 0;
      end
      6: m_taken = m_cond(cc);
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (bus.BUSY && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (bus.BUSY) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: BUSY still 1 after %0d cycles", budget);
    end
  endtask

  // Issue one op; with hold=1, START stays high through the busy cycles.
  task automatic do_op(input int op, input int d, input int cc, input bit hold);
    exp_t e;
    @(negedge clk);
    wait_idle();
    bus.START = 1'b1;
    bus.OP    = 3'(op);
    bus.D     = 8'(d);
    bus.CC    = 4'(cc);
    model_apply(op, d, cc);
    @(posedge clk);
    #1;
    e.acc = m_acc; e.flags = m_flags(); e.taken = m_taken; e.cyc = cyc; e.op = op;
    sb.push_back(e);
    if (hold) begin
      bus.D = 8'h22;
      repeat (2) @(posedge clk);
      #1;
    end
    bus.START = 1'b0;
    bus.OP    = 3'($urandom_range(0, 7));
    bus.D     = 8'($urandom_range(0, 255));
    bus.CC    = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_state(input string name, input int acc, input int flags, input int taken);
    @(negedge clk);
    wait_idle();
    chk({name, "_acc"}, int'(bus.ACC), acc);
    chk({name, "_flags"}, int'(bus.FLAGS), flags);
    chk({name, "_taken"}, int'(bus.TAKEN), taken);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  exp_t got;
  always @(negedge clk) begin
    if (!rst && bus.DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DONE=1 with no op outstanding (t=%0t)", $time);
      end else begin
        got = sb.pop_front();
        chk("done_latency", cyc, got.cyc + 1);
        chk("sb_acc", int'(bus.ACC), got.acc);
        chk("sb_flags", int'(bus.FLAGS), got.flags);
        chk("sb_taken", int'(bus.TAKEN), got.taken);
        chk("sb_busy", int'(bus.BUSY), 1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.OP = '0;
    bus.D = '0;
    bus.CC = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_acc", int'(bus.ACC), 0);
    chk("rst_flags", int'(bus.FLAGS), 0);
    chk("rst_taken", int'(bus.TAKEN), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);

    // Signed overflow on ADD.
    do_op(1, 8'h7F, 0, 1'b0);
    do_op(2, 8'h01, 0, 1'b0);
    chk_state("add_ovf", 8'h80, 4'b0110, 0);

    // SUB to zero then EQ.
    do_op(1, 8'h05, 0, 1'b0);
    do_op(3, 8'h05, 0, 1'b0);
    chk_state("sub_zero", 8'h00, 4'b1001, 0);
    do_op(6, 0, 4'h0, 1'b0);
    chk_state("tst_eq", 8'h00, 4'b1001, 1);

    // CMP with borrow and several conditions.
    do_op(1, 8'h05, 0, 1'b0);
    do_op(4, 8'h10, 0, 1'b0);
    chk_state("cmp", 8'h05, 4'b0010, 1);
    do_op(6, 0, 4'hB, 1'b0);
    chk_state("tst_lt", 8'h05, 4'b0010, 1);
    do_op(6, 0, 4'h3, 1'b0);
    chk_state("tst_cc", 8'h05, 4'b0010, 1);
    do_op(6, 0, 4'h8, 1'b0);
    chk_state("tst_hi", 8'h05, 4'b0010, 0);

    // Carry wrap, LDA preserving C, then CLF.
    do_op(1, 8'hFF, 0, 1'b0);
    do_op(2, 8'h01, 0, 1'b0);
    chk_state("add_wrap", 8'h00, 4'b1001, 0);
    do_op(1, 8'h00, 0, 1'b0);
    chk_state("lda_keep_c", 8'h00, 4'b1001, 0);
    do_op(5, 0, 0, 1'b0);
    chk_state("clf", 8'h00, 4'b0000, 0);

    // START held through BUSY executes once; reserved opcode is a no-op.
    do_op(2, 8'h11, 0, 1'b1);
    chk_state("start_held", 8'h11, 4'b0000, 0);
    do_op(7, 8'h99, 4'hE, 1'b0);
    chk_state("op_rsv", 8'h11, 4'b0000, 0);

    // Reset during EXEC aborts the op.
    @(negedge clk);
    wait_idle();
    bus.START = 1'b1;
    bus.OP = 3'd2;
    bus.D = 8'h33;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_done", int'(bus.DONE), 0);
    chk("abort_acc", int'(bus.ACC), 0);
    chk("abort_flags", int'(bus.FLAGS), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", int'(bus.DONE), 0);

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      int op;
      op = (i % 8 == 0) ? 1 : int'($urandom_range(0, 7));
      do_op(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    begin
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("sb_drained", sb.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
